// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared state encoding, RAM direction codes and helpers for
//               the instruction-RAM program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] RECV  = 3'd1;
    localparam logic [STATE_W-1:0] WRITE = 3'd2;
    localparam logic [STATE_W-1:0] CHECK = 3'd3;
    localparam logic [STATE_W-1:0] DONE  = 3'd4;

    localparam logic RAM_WRITE = 1'b0;
    localparam logic RAM_READ  = 1'b1;

    // States in which the byte stream is consumed.
    function automatic logic is_stream_state(input logic [STATE_W-1:0] s);
        return (s == RECV) || (s == CHECK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_if
// Description : Host byte stream, load control/status and RAM write port of
//               the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_loader_if #(
    parameter int CNT_W = 9
) ();

    logic             start;
    logic [CNT_W-1:0] length;
    logic [7:0]       byte_in;
    logic             byte_valid;
    logic             byte_ready;
    logic             enable;
    logic             rw_ram;
    logic [31:0]      address_out;
    logic [31:0]      in_data;
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start, length, byte_in, byte_valid,
        input  byte_ready, enable, rw_ram, address_out, in_data,
        input  cpu_hold, busy, done, error
    );

    modport slave (
        input  start, length, byte_in, byte_valid,
        output byte_ready, enable, rw_ram, address_out, in_data,
        output cpu_hold, busy, done, error
    );

endinterface
`default_nettype wire

// File: rtl/program_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Big-endian byte-to-word packer; flags the word on its 4th byte.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        clear,
    input  wire logic [7:0]  byte_in,
    input  wire logic        take,
    output logic      [31:0] word,
    output logic             word_valid
);

    logic [1:0]  r_pos;
    logic [31:0] r_shift;

    // The completed word is presented in the same cycle as its last byte.
    assign word       = {r_shift[23:0], byte_in};
    assign word_valid = take && (r_pos == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_pos   <= 2'd0;
            r_shift <= 32'd0;
        end else if (take) begin
            r_pos   <= r_pos + 2'd1;
            r_shift <= word;
        end
    end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Fills instruction RAM from a byte stream, verifies a trailing
//               XOR checksum and holds the CPU until a good image is loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 9
) (
    input  wire logic       clk,
    input  wire logic       reset,
    program_loader_if.slave bus
);

    localparam logic [CNT_W-1:0] c_max_words = CNT_W'(MAX_WORDS);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;

    logic [CNT_W-1:0]   r_length;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_checksum;

    logic               r_enable;
    logic               r_rw_ram;
    logic [31:0]        r_address;
    logic [31:0]        r_in;
    logic               r_cpu_hold;
    logic               r_busy;
    logic               r_done;
    logic               r_error;

    logic               w_enable_d;
    logic               w_rw_ram_d;
    logic [31:0]        w_address_d;
    logic [31:0]        w_in_d;
    logic               w_cpu_hold_d;
    logic               w_busy_d;
    logic               w_done_d;
    logic               w_error_d;

    logic               w_ready;
    logic               w_take;
    logic               w_start;
    logic               w_len_bad;
    logic               w_last_word;
    logic [31:0]        w_pack_word;
    logic               w_pack_valid;

    assign w_ready     = is_stream_state(r_state);
    assign w_take      = bus.byte_valid && w_ready;
    assign w_start     = (r_state == IDLE) && bus.start;
    assign w_len_bad   = bus.length > c_max_words;
    assign w_last_word = (r_count + CNT_W'(1)) == r_length;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_start),
        .byte_in    (bus.byte_in),
        .take       (w_take),
        .word       (w_pack_word),
        .word_valid (w_pack_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_len_bad) begin
                        w_next_state = DONE;
                    end else if (bus.length == '0) begin
                        w_next_state = CHECK;
                    end else begin
                        w_next_state = RECV;
                    end
                end
            end
            RECV: begin
                if (w_pack_valid) begin
                    w_next_state = WRITE;
                end
            end
            WRITE: begin
                w_next_state = w_last_word ? CHECK : RECV;
            end
            CHECK: begin
                if (w_pack_valid) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Next values of the registered outputs, keyed on the state being entered
    // so that every output lines up with the state it belongs to.
    always_comb begin
        w_enable_d   = (w_next_state == WRITE);
        w_rw_ram_d   = (w_next_state == WRITE) ? RAM_WRITE : RAM_READ;
        w_address_d  = r_address;
        w_in_d       = r_in;
        w_busy_d     = (w_next_state == RECV) || (w_next_state == WRITE) ||
                       (w_next_state == CHECK);
        w_done_d     = (w_next_state == DONE);
        w_error_d    = r_error;
        w_cpu_hold_d = r_cpu_hold;

        if (w_start) begin
            w_error_d    = w_len_bad;
            w_cpu_hold_d = 1'b1;
        end

        if ((r_state == RECV) && w_pack_valid) begin
            w_address_d = BASE_ADDR + {{(32-CNT_W){1'b0}}, r_count};
            w_in_d      = w_pack_word;
        end

        if ((r_state == CHECK) && w_pack_valid) begin
            w_error_d = (w_pack_word != r_checksum);
        end

        if (w_next_state == DONE) begin
            w_cpu_hold_d = w_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_length   <= '0;
            r_count    <= '0;
            r_checksum <= 32'd0;
            r_enable   <= 1'b0;
            r_rw_ram   <= RAM_READ;
            r_address  <= 32'd0;
            r_in       <= 32'd0;
            r_cpu_hold <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_start) begin
                r_length   <= bus.length;
                r_count    <= '0;
                r_checksum <= 32'd0;
            end else if (r_state == WRITE) begin
                r_count    <= r_count + CNT_W'(1);
                r_checksum <= r_checksum ^ r_in;
            end
            r_enable   <= w_enable_d;
            r_rw_ram   <= w_rw_ram_d;
            r_address  <= w_address_d;
            r_in       <= w_in_d;
            r_cpu_hold <= w_cpu_hold_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_error    <= w_error_d;
        end
    end

    assign bus.byte_ready  = w_ready;
    assign bus.enable      = r_enable;
    assign bus.rw_ram      = r_rw_ram;
    assign bus.address_out = r_address;
    assign bus.in_data     = r_in;
    assign bus.cpu_hold    = r_cpu_hold;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Randomized scoreboard bench for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int          CNT_W     = 9;
    localparam int          MAX_WORDS = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0040;

    logic clk;
    logic reset;

    program_loader_if #(.CNT_W(CNT_W)) bus ();

    program_loader #(
        .BASE_ADDR (BASE_ADDR),
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;

    logic [63:0] exp_wr  [$];
    logic        exp_err [$];
    logic [31:0] img     [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every RAM write and every Done pulse is matched
    // against the expectation queues filled by the stimulus side.
    always @(negedge clk) begin
        logic [63:0] e;
        logic        ee;
        if (bus.enable) begin
            check("rw_on_write", 64'(bus.rw_ram), 64'(0));
            check("hold_on_write", 64'(bus.cpu_hold), 64'(1));
            if (exp_wr.size() == 0) begin
                check("unexpected_write", {bus.address_out, bus.in_data}, 64'(0));
            end else begin
                e = exp_wr.pop_front();
                check("write_addr", 64'(bus.address_out), 64'(e[63:32]));
                check("write_data", 64'(bus.in_data), 64'(e[31:0]));
            end
        end else begin
            check("rw_idle", 64'(bus.rw_ram), 64'(1));
        end
        if (bus.done) begin
            n_done++;
            if (exp_err.size() == 0) begin
                check("unexpected_done", 64'(bus.done), 64'(0));
            end else begin
                ee = exp_err.pop_front();
                check("done_error", 64'(bus.error), 64'(ee));
                check("done_cpu_hold", 64'(bus.cpu_hold), 64'(ee));
                check("done_busy", 64'(bus.busy), 64'(0));
            end
        end
    end

    task automatic pulse_start(input int len);
        bus.start  = 1'b1;
        bus.length = CNT_W'(len);
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int smode);
        int  waited;
        logic stall;
        waited = 0;
        stall  = (smode == 1) || ((smode == 2) && ($urandom_range(0, 2) == 0));
        if (stall) begin
            bus.byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.byte_ready) break;
            waited++;
            if (waited > 50) begin
                check("byte_accept_timeout", 64'(bus.byte_ready), 64'(1));
                break;
            end
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int smode);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[31-8*k -: 8], smode);
        end
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && n_done < target; i++) begin
            @(posedge clk); #1;
        end
        check("done_seen", 64'(n_done >= target), 64'(1));
        @(posedge clk); #1;
    endtask

    // Reference model: an image of len words lands at BASE_ADDR upward and
    // the load fails on a bad length or a checksum unequal to the XOR.
    task automatic expect_load(input int len, input logic [31:0] chk);
        logic [31:0] x;
        x = 32'd0;
        if (len > MAX_WORDS) begin
            exp_err.push_back(1'b1);
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_wr.push_back({BASE_ADDR + 32'(i), img[i]});
                x = x ^ img[i];
            end
            exp_err.push_back(chk != x);
        end
    endtask

    task automatic run_load(input int len, input logic [31:0] chk, input int smode);
        int target;
        expect_load(len, chk);
        target = n_done + 1;
        pulse_start(len);
        if (len <= MAX_WORDS) begin
            check("busy_after_start", 64'(bus.busy), 64'(1));
            for (int i = 0; i < len; i++) send_word(img[i], smode);
            send_word(chk, smode);
        end
        wait_done(target);
        check("pending_writes", 64'(exp_wr.size()), 64'(0));
    endtask

    initial begin
        int          len;
        int          target;
        logic [31:0] x;
        logic [31:0] chk;

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.length     = '0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_byte_ready", 64'(bus.byte_ready), 64'(0));
        check("rst_enable", 64'(bus.enable), 64'(0));
        check("rst_rw_ram", 64'(bus.rw_ram), 64'(1));
        check("rst_address", 64'(bus.address_out), 64'(0));
        check("rst_in", 64'(bus.in_data), 64'(0));
        check("rst_cpu_hold", 64'(bus.cpu_hold), 64'(1));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_error", 64'(bus.error), 64'(0));
        @(posedge clk); #1;

        // Basic load, then the same image with a zero checksum.
        img = '{32'hE3A0_0001, 32'h1234_5678};
        run_load(2, 32'hF194_5679, 0);
        check("basic_hold_after", 64'(bus.cpu_hold), 64'(0));
        run_load(2, 32'h0000_0000, 0);
        check("badchk_hold_after", 64'(bus.cpu_hold), 64'(1));

        // Stalled stream with Byte_valid toggling every cycle.
        img = '{32'hDEAD_BEEF};
        run_load(1, 32'hDEAD_BEEF, 1);

        // Length bounds.
        img.delete();
        run_load(MAX_WORDS + 1, 32'h0, 0);
        check("ovr_ready_idle", 64'(bus.byte_ready), 64'(0));
        run_load(0, 32'h0, 0);

        // Reset after 6 bytes of a 3-word load.
        img = '{32'hA1B2_C3D4, 32'h5566_7788, 32'h99AA_BBCC};
        exp_wr.push_back({BASE_ADDR, img[0]});
        pulse_start(3);
        send_word(img[0], 0);
        send_byte(img[1][31:24], 0);
        send_byte(img[1][23:16], 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_cpu_hold", 64'(bus.cpu_hold), 64'(1));
        check("midrst_pending", 64'(exp_wr.size()), 64'(0));
        img = '{32'h0BAD_F00D};
        run_load(1, 32'h0BAD_F00D, 0);

        // Second Start during RECV must not relatch Length.
        img = '{32'h1111_2222, 32'h3333_4444};
        expect_load(2, 32'h2222_6666);
        target = n_done + 1;
        pulse_start(2);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        pulse_start(1);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        send_word(img[1], 0);
        send_word(32'h2222_6666, 0);
        wait_done(target);
        check("busystart_pending", 64'(exp_wr.size()), 64'(0));

        // Randomized images.
        for (int t = 0; t < 14; t++) begin
            img.delete();
            if ($urandom_range(0, 7) == 0) len = $urandom_range(MAX_WORDS + 1, 511);
            else                           len = $urandom_range(0, 6);
            x = 32'd0;
            if (len <= MAX_WORDS) begin
                for (int i = 0; i < len; i++) begin
                    img.push_back($urandom);
                    x = x ^ img[i];
                end
            end
            chk = ($urandom_range(0, 3) == 0) ? $urandom : x;
            run_load(len, chk, 2);
        end

        check("results_drained", 64'(exp_err.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
